pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Parametrised hazard, forwarding and flush controller for the 5-stage pipeline (fetch, decode, ALU, memory, write-back). It keeps its own shadow of the destination registers of instructions in the ALU, memory and write-back stages. Each cycle it decides stall, bubble, flush and per-operand forwarding for the instruction leaving decode. Beyond plain forwarding, it adds a no-forwarding mode, a global freeze and saturating stall/flush performance counters.

## Interface
- ADDR_W, 3, register address width (2^ADDR_W general registers, all writable, no hard-wired zero)
- FWD_EN, 1, 1 = full forwarding; 0 = interlock-only (stall until producer retired)
- CNT_W, 16, width of performance counters
- clk  in  1  pipeline clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- d_valid  in  1  decode holds a real instruction
- d_rs1 / d_rs2  in  ADDR_W  decode source registers
- d_rs1_used / d_rs2_used  in  1  source actually read
- d_rd  in  ADDR_W  decode destination
- d_wb  in  1  decode instruction writes back
- d_mem_read  in  1  decode instruction is a load
- jump_taken  in  1  instruction currently in ALU stage resolved a taken jump
- freeze  in  1  external hold of the entire pipeline
- stall_f / stall_d  out  1  hold fetch PC / decode register
- bubble_e  out  1  ALU-stage register loads a NOP
- flush_d  out  1  decode register loads a NOP
- fwd_sel1 / fwd_sel2  out  2  operand source for the instruction in ALU stage: 0 regfile, 1 ALU/MEM buffer, 2 MEM/WB buffer, 3 last retired WB value
- stall_cnt / flush_cnt  out  CNT_W  saturating counters

## Operation
- Shadow entries E, M, W, each {valid, wb, mem_read, rd}. All are invalid after reset.
- Match(S, rs) = S.valid & S.wb & S.rd==rs & rs_used & d_valid.
- Hazard with FWD_EN=1: Match(E, rs1|rs2) with E.mem_read (load-use).
- Hazard with FWD_EN=0: any Match(E|M|W, rs1|rs2).
- Priority per cycle: freeze > jump_taken > hazard > normal.
- Freeze:
  - stall_f = stall_d = 1, bubble_e = flush_d = 0.
  - Shadows, fwd_sel and counters hold.
  - jump_taken and hazards are acted on in the first unfrozen cycle.
- Jump (jump_taken & ~freeze):
  - flush_d = 1, bubble_e = 1, stall_f = stall_d = 0.
  - Shadow E is loaded invalid; fwd_sel becomes 0.
  - flush_cnt increments; any coincident hazard is discarded and not counted.
- Hazard (no freeze, no jump):
  - stall_f = stall_d = bubble_e = 1.
  - Shadow E is loaded invalid; fwd_sel becomes 0; stall_cnt increments.
- Normal:
  - All control outputs are 0.
  - Shadow E is loaded with decode info (valid = d_valid).
  - fwd_selN is registered as follows:
    - 1 if Match(E, rsN);
    - else 2 if Match(M, rsN);
    - else 3 if Match(W, rsN);
    - else 0.
  - When FWD_EN=0, fwd_sel is always 0.
- Shadow advance on every unfrozen cycle: W<=M, M<=E.
- Counters saturate at 2^CNT_W-1 and never wrap.
- The unit performs no arithmetic on data; it produces control only.

## Timing
- stall_f, stall_d, bubble_e and flush_d are combinational from current shadow state plus the d_*, jump_taken and freeze inputs, in the same cycle.
- fwd_sel1/2 are registered and valid for the whole cycle the consuming instruction occupies the ALU stage.
- Load-use with FWD_EN=1:
  - exactly one stall cycle;
  - the consumer then enters ALU with fwd_sel=2.
- FWD_EN=0, producer directly ahead:
  - 3 stall cycles;
  - the consumer enters with fwd_sel=0.
- Jump penalty: two squashed slots (decode and fetch contents).
- Reset asserted at any time:
  - outputs are immediately 0 (fwd_sel=0, counters=0, stall/bubble/flush=0);
  - shadows are invalid;
  - the first post-reset cycle has no hazard.
- Simultaneous rs1 and rs2 matches are resolved independently per operand.
- A match on both E and M for the same register selects the youngest (E → code 1).

## Test plan
- ADD R1 then ADD R2,R1,R1 back-to-back (FWD_EN=1) -> no stall; second op in ALU with fwd_sel1=fwd_sel2=1.
- Producer R4, then consumers of R4 at distance 2, 3, 4 (one each) -> fwd_sel1 = 2, 3, 0 respectively; stall_cnt stays 0.
- LDD R3 followed by ADD R5,R3 -> exactly 1 cycle with stall_f=stall_d=bubble_e=1; consumer gets fwd_sel1=2; stall_cnt=1.
- Load-use hazard present in the same cycle as jump_taken=1 -> flush_d=bubble_e=1, stall_d=0; flush_cnt=1, stall_cnt=0.
- FWD_EN=0: ADD R1 then use R1 -> 3 consecutive stall cycles, stall_cnt=3, consumer fwd_sel1=0; a 2-cycle freeze inserted mid-stall -> stall_cnt still 3, total hold 5 cycles.
- Reset asserted during an active stall, plus a counter at saturation (CNT_W=4, 16 hazards) -> outputs 0 immediately on reset; in the saturation run, stall_cnt holds at 15.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//
// Hazard, forwarding and flush controller for a 5-stage pipeline
// (fetch, decode, ALU, memory, write-back). It keeps a shadow copy of the
// destination info of the instructions in the ALU (E), memory (M) and
// write-back (W) stages. Each cycle it decides whether the instruction
// leaving decode must stall, be flushed or use forwarded operands.
//
// Parameters
//   ADDR_W : register address width
//   FWD_EN : 1 = full forwarding, 0 = interlock until the producer retires
//   CNT_W  : width of the saturating stall/flush counters
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   d_valid                    decode holds a real instruction
//   d_rs1/d_rs2, d_rsN_used    decode source registers and their use flags
//   d_rd, d_wb, d_mem_read     decode destination, writes-back, is-load
//   jump_taken                 ALU-stage instruction resolved a taken jump
//   freeze                     external hold of the whole pipeline
//   stall_f, stall_d           hold fetch PC / decode register (comb)
//   bubble_e                   ALU-stage register loads a NOP (comb)
//   flush_d                    decode register loads a NOP (comb)
//   fwd_sel1, fwd_sel2         registered operand source for the ALU stage:
//                              0 regfile, 1 ALU/MEM, 2 MEM/WB, 3 retired WB
//   stall_cnt, flush_cnt       saturating performance counters

module pipe_hazard_ctrl #(
  parameter int ADDR_W = 3,
  parameter bit FWD_EN = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              d_valid,
  input  logic [ADDR_W-1:0] d_rs1,
  input  logic [ADDR_W-1:0] d_rs2,
  input  logic              d_rs1_used,
  input  logic              d_rs2_used,
  input  logic [ADDR_W-1:0] d_rd,
  input  logic              d_wb,
  input  logic              d_mem_read,
  input  logic              jump_taken,
  input  logic              freeze,
  output logic              stall_f,
  output logic              stall_d,
  output logic              bubble_e,
  output logic              flush_d,
  output logic [1:0]        fwd_sel1,
  output logic [1:0]        fwd_sel2,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef struct packed {
    logic              valid;
    logic              wb;
    logic              mem_read;
    logic [ADDR_W-1:0] rd;
  } shadow_t;

  shadow_t sh_e, sh_m, sh_w;

  logic m_e1, m_m1, m_w1;
  logic m_e2, m_m2, m_w2;
  logic hazard;
  logic [1:0] sel1_nxt, sel2_nxt;

  function automatic logic match(input shadow_t s, input logic [ADDR_W-1:0] rs,
                                 input logic used, input logic dv);
    return s.valid & s.wb & (s.rd == rs) & used & dv;
  endfunction

  // Youngest producer wins: E before M before W.
  function automatic logic [1:0] pick(input logic me, input logic mm, input logic mw);
    if (me)      return 2'd1;
    else if (mm) return 2'd2;
    else if (mw) return 2'd3;
    else         return 2'd0;
  endfunction

  always_comb begin
    m_e1 = match(sh_e, d_rs1, d_rs1_used, d_valid);
    m_m1 = match(sh_m, d_rs1, d_rs1_used, d_valid);
    m_w1 = match(sh_w, d_rs1, d_rs1_used, d_valid);
    m_e2 = match(sh_e, d_rs2, d_rs2_used, d_valid);
    m_m2 = match(sh_m, d_rs2, d_rs2_used, d_valid);
    m_w2 = match(sh_w, d_rs2, d_rs2_used, d_valid);
    // With forwarding only a load directly ahead cannot be bypassed; without
    // it every in-flight producer must drain first.
    if (FWD_EN)
      hazard = sh_e.mem_read & (m_e1 | m_e2);
    else
      hazard = m_e1 | m_e2 | m_m1 | m_m2 | m_w1 | m_w2;
    sel1_nxt = FWD_EN ? pick(m_e1, m_m1, m_w1) : 2'd0;
    sel2_nxt = FWD_EN ? pick(m_e2, m_m2, m_w2) : 2'd0;
  end

  // Control outputs are forced low while reset is held so they drop at once,
  // regardless of freeze/jump inputs.
  always_comb begin
    stall_f  = 1'b0;
    stall_d  = 1'b0;
    bubble_e = 1'b0;
    flush_d  = 1'b0;
    if (!reset) begin
      if (freeze) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
      end else if (jump_taken) begin
        bubble_e = 1'b1;
        flush_d  = 1'b1;
      end else if (hazard) begin
        stall_f  = 1'b1;
        stall_d  = 1'b1;
        bubble_e = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_e      <= '0;
      sh_m      <= '0;
      sh_w      <= '0;
      fwd_sel1  <= 2'd0;
      fwd_sel2  <= 2'd0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (!freeze) begin
      sh_w <= sh_m;
      sh_m <= sh_e;
      if (jump_taken || hazard) begin
        sh_e     <= '0;
        fwd_sel1 <= 2'd0;
        fwd_sel2 <= 2'd0;
        // A hazard coincident with a jump is squashed along with decode.
        if (jump_taken) begin
          if (flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
        end else begin
          if (stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
        end
      end else begin
        sh_e     <= '{valid: d_valid, wb: d_wb, mem_read: d_mem_read, rd: d_rd};
        fwd_sel1 <= sel1_nxt;
        fwd_sel2 <= sel2_nxt;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl
//
// Three controller instances share one stimulus stream: a forwarding
// instance (a), an interlock-only instance (b) and a forwarding instance
// with 4-bit counters (c). Expected values are queued when stimulus is
// driven; combinational ones are checked shortly after the drive, registered
// ones after the following clock edge.

module tb_pipe_hazard_ctrl;

  localparam int AW = 3;

  localparam int A_CTRL = 0, A_FWD = 1, A_SCNT = 2,  A_FCNT = 3;
  localparam int B_CTRL = 4, B_FWD = 5, B_SCNT = 6,  B_FCNT = 7;
  localparam int C_CTRL = 8, C_FWD = 9, C_SCNT = 10, C_FCNT = 11;

  logic          clk, reset;
  logic          d_valid, d_rs1_used, d_rs2_used, d_wb, d_mem_read;
  logic [AW-1:0] d_rs1, d_rs2, d_rd;
  logic          jump_taken, freeze;

  logic        a_sf, a_sd, a_be, a_fd, b_sf, b_sd, b_be, b_fd, c_sf, c_sd, c_be, c_fd;
  logic [1:0]  a_f1, a_f2, b_f1, b_f2, c_f1, c_f2;
  logic [15:0] a_sc, a_fc, b_sc, b_fc;
  logic [3:0]  c_sc, c_fc;

  pipe_hazard_ctrl #(.ADDR_W(AW), .FWD_EN(1'b1), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2),
    .d_rs1_used(d_rs1_used), .d_rs2_used(d_rs2_used), .d_rd(d_rd), .d_wb(d_wb),
    .d_mem_read(d_mem_read), .jump_taken(jump_taken), .freeze(freeze),
    .stall_f(a_sf), .stall_d(a_sd), .bubble_e(a_be), .flush_d(a_fd),
    .fwd_sel1(a_f1), .fwd_sel2(a_f2), .stall_cnt(a_sc), .flush_cnt(a_fc));

  pipe_hazard_ctrl #(.ADDR_W(AW), .FWD_EN(1'b0), .CNT_W(16)) dut_b (
    .clk(clk), .reset(reset), .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2),
    .d_rs1_used(d_rs1_used), .d_rs2_used(d_rs2_used), .d_rd(d_rd), .d_wb(d_wb),
    .d_mem_read(d_mem_read), .jump_taken(jump_taken), .freeze(freeze),
    .stall_f(b_sf), .stall_d(b_sd), .bubble_e(b_be), .flush_d(b_fd),
    .fwd_sel1(b_f1), .fwd_sel2(b_f2), .stall_cnt(b_sc), .flush_cnt(b_fc));

  pipe_hazard_ctrl #(.ADDR_W(AW), .FWD_EN(1'b1), .CNT_W(4)) dut_c (
    .clk(clk), .reset(reset), .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2),
    .d_rs1_used(d_rs1_used), .d_rs2_used(d_rs2_used), .d_rd(d_rd), .d_wb(d_wb),
    .d_mem_read(d_mem_read), .jump_taken(jump_taken), .freeze(freeze),
    .stall_f(c_sf), .stall_d(c_sd), .bubble_e(c_be), .flush_d(c_fd),
    .fwd_sel1(c_f1), .fwd_sel2(c_f2), .stall_cnt(c_sc), .flush_cnt(c_fc));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    string tag;
    int    sig;
    int    val;
  } exp_t;

  exp_t q_comb[$];
  exp_t q_reg[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check_val(input string tag, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  // ctrl packs {stall_f, stall_d, bubble_e, flush_d}; fwd packs {sel1, sel2}.
  function automatic int obs(input int sig);
    case (sig)
      A_CTRL: return int'({a_sf, a_sd, a_be, a_fd});
      A_FWD:  return int'({a_f1, a_f2});
      A_SCNT: return int'(a_sc);
      A_FCNT: return int'(a_fc);
      B_CTRL: return int'({b_sf, b_sd, b_be, b_fd});
      B_FWD:  return int'({b_f1, b_f2});
      B_SCNT: return int'(b_sc);
      B_FCNT: return int'(b_fc);
      C_CTRL: return int'({c_sf, c_sd, c_be, c_fd});
      C_FWD:  return int'({c_f1, c_f2});
      C_SCNT: return int'(c_sc);
      C_FCNT: return int'(c_fc);
      default: return -1;
    endcase
  endfunction

  task automatic exp_c(input string tag, input int sig, input int val);
    exp_t e;
    e.tag = tag; e.sig = sig; e.val = val;
    q_comb.push_back(e);
  endtask

  task automatic exp_r(input string tag, input int sig, input int val);
    exp_t e;
    e.tag = tag; e.sig = sig; e.val = val;
    q_reg.push_back(e);
  endtask

  task automatic drain_comb();
    exp_t e;
    while (q_comb.size() > 0) begin
      e = q_comb.pop_front();
      check_val(e.tag, obs(e.sig), e.val);
    end
  endtask

  task automatic drain_reg();
    exp_t e;
    while (q_reg.size() > 0) begin
      e = q_reg.pop_front();
      check_val(e.tag, obs(e.sig), e.val);
    end
  endtask

  // Called at a falling edge after inputs are driven.
  task automatic step();
    #2;
    drain_comb();
    @(negedge clk);
    drain_reg();
  endtask

  task automatic dec(input logic v, input int rs1, input logic u1, input int rs2,
                     input logic u2, input int rd, input logic wb, input logic mr);
    d_valid    = v;
    d_rs1      = AW'(rs1);
    d_rs1_used = u1;
    d_rs2      = AW'(rs2);
    d_rs2_used = u2;
    d_rd       = AW'(rd);
    d_wb       = wb;
    d_mem_read = mr;
  endtask

  task automatic idle();
    dec(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    jump_taken = 1'b0;
    freeze     = 1'b0;
    idle();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset      = 1'b0;
    jump_taken = 1'b0;
    freeze     = 1'b0;
    idle();

    // Reset state, with freeze and jump asserted to show outputs still drop.
    #1;
    reset      = 1'b1;
    jump_taken = 1'b1;
    freeze     = 1'b1;
    #2;
    exp_c("rst_a_ctrl", A_CTRL, 0);
    exp_c("rst_b_ctrl", B_CTRL, 0);
    exp_c("rst_c_ctrl", C_CTRL, 0);
    exp_c("rst_a_fwd",  A_FWD,  0);
    exp_c("rst_a_scnt", A_SCNT, 0);
    exp_c("rst_a_fcnt", A_FCNT, 0);
    drain_comb();
    jump_taken = 1'b0;
    freeze     = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // Back-to-back ALU dependency: forwarded from ALU/MEM on both operands.
    dec(1'b1, 0, 1'b0, 0, 1'b0, 1, 1'b1, 1'b0);
    exp_c("b2b_p_ctrl", A_CTRL, 0);
    step();
    dec(1'b1, 1, 1'b1, 1, 1'b1, 2, 1'b1, 1'b0);
    exp_c("b2b_c_ctrl", A_CTRL, 0);
    exp_r("b2b_fwd", A_FWD, 4'b0101);
    step();
    idle();
    exp_r("b2b_idle_fwd", A_FWD, 0);
    exp_r("b2b_scnt", A_SCNT, 0);
    step();

    // Producer R4 then consumers at distance 2, 3, 4; first consumer also
    // reads R7 from the instruction directly ahead on rs2.
    do_reset();
    dec(1'b1, 0, 1'b0, 0, 1'b0, 4, 1'b1, 1'b0);
    step();
    dec(1'b1, 0, 1'b0, 0, 1'b0, 7, 1'b1, 1'b0);
    step();
    dec(1'b1, 4, 1'b1, 7, 1'b1, 5, 1'b1, 1'b0);
    exp_c("dist2_ctrl", A_CTRL, 0);
    exp_r("dist2_fwd", A_FWD, 4'b1001);
    step();
    dec(1'b1, 4, 1'b1, 0, 1'b0, 6, 1'b1, 1'b0);
    exp_c("dist3_ctrl", A_CTRL, 0);
    exp_r("dist3_fwd", A_FWD, 4'b1100);
    step();
    dec(1'b1, 4, 1'b1, 0, 1'b0, 0, 1'b1, 1'b0);
    exp_c("dist4_ctrl", A_CTRL, 0);
    exp_r("dist4_fwd", A_FWD, 0);
    exp_r("dist_scnt", A_SCNT, 0);
    step();
    idle();
    step();

    // Load-use: one stall cycle, consumer then reads MEM/WB.
    do_reset();
    dec(1'b1, 0, 1'b0, 0, 1'b0, 3, 1'b1, 1'b1);
    exp_c("lu_ld_ctrl", A_CTRL, 0);
    step();
    dec(1'b1, 3, 1'b1, 0, 1'b0, 5, 1'b1, 1'b0);
    exp_c("lu_stall_ctrl", A_CTRL, 4'b1110);
    exp_r("lu_stall_fwd", A_FWD, 0);
    exp_r("lu_stall_scnt", A_SCNT, 1);
    step();
    exp_c("lu_go_ctrl", A_CTRL, 0);
    exp_r("lu_go_fwd", A_FWD, 4'b1000);
    exp_r("lu_go_scnt", A_SCNT, 1);
    step();
    idle();
    step();

    // Load-use coinciding with a taken jump: the flush wins.
    do_reset();
    dec(1'b1, 0, 1'b0, 0, 1'b0, 3, 1'b1, 1'b1);
    step();
    dec(1'b1, 3, 1'b1, 0, 1'b0, 5, 1'b1, 1'b0);
    jump_taken = 1'b1;
    exp_c("jmp_ctrl", A_CTRL, 4'b0011);
    exp_r("jmp_fcnt", A_FCNT, 1);
    exp_r("jmp_scnt", A_SCNT, 0);
    exp_r("jmp_fwd", A_FWD, 0);
    step();
    jump_taken = 1'b0;
    idle();
    step();

    // Interlock-only instance: three stalls with a two-cycle freeze inside.
    do_reset();
    dec(1'b1, 0, 1'b0, 0, 1'b0, 1, 1'b1, 1'b0);
    exp_c("nf_p_ctrl", B_CTRL, 0);
    step();
    dec(1'b1, 1, 1'b1, 0, 1'b0, 2, 1'b1, 1'b0);
    exp_c("nf_s1_ctrl", B_CTRL, 4'b1110);
    step();
    exp_c("nf_s2_ctrl", B_CTRL, 4'b1110);
    exp_r("nf_s2_scnt", B_SCNT, 2);
    step();
    freeze = 1'b1;
    exp_c("nf_fz1_ctrl", B_CTRL, 4'b1100);
    step();
    exp_c("nf_fz2_ctrl", B_CTRL, 4'b1100);
    exp_r("nf_fz_scnt", B_SCNT, 2);
    step();
    freeze = 1'b0;
    exp_c("nf_s3_ctrl", B_CTRL, 4'b1110);
    exp_r("nf_s3_scnt", B_SCNT, 3);
    step();
    exp_c("nf_go_ctrl", B_CTRL, 0);
    exp_r("nf_go_fwd", B_FWD, 0);
    exp_r("nf_go_scnt", B_SCNT, 3);
    step();
    idle();
    step();

    // Reset asserted mid-cycle during an active stall with nonzero state.
    do_reset();
    dec(1'b1, 0, 1'b0, 0, 1'b0, 3, 1'b1, 1'b1);
    step();
    dec(1'b1, 3, 1'b1, 0, 1'b0, 5, 1'b1, 1'b0);
    step();
    step();
    dec(1'b1, 5, 1'b1, 0, 1'b0, 3, 1'b1, 1'b1);
    step();
    dec(1'b1, 3, 1'b1, 0, 1'b0, 6, 1'b1, 1'b0);
    exp_c("mr_pre_ctrl", A_CTRL, 4'b1110);
    exp_c("mr_pre_fwd", A_FWD, 4'b0100);
    exp_c("mr_pre_scnt", A_SCNT, 1);
    #2;
    drain_comb();
    reset = 1'b1;
    #1;
    exp_c("mr_ctrl", A_CTRL, 0);
    exp_c("mr_fwd", A_FWD, 0);
    exp_c("mr_scnt", A_SCNT, 0);
    drain_comb();
    @(negedge clk);
    reset = 1'b0;
    exp_c("mr_post_ctrl", A_CTRL, 0);
    step();
    idle();
    step();

    // Counter saturation: self-dependent load stalls every other cycle.
    do_reset();
    dec(1'b1, 3, 1'b1, 0, 1'b0, 3, 1'b1, 1'b1);
    for (int i = 0; i < 40; i++) begin
      exp_c($sformatf("sat_ctrl_%0d", i), C_CTRL, (i % 2 == 1) ? 4'b1110 : 0);
      if (i == 27) exp_r("sat_c_14", C_SCNT, 14);
      if (i == 29) exp_r("sat_c_15", C_SCNT, 15);
      if (i == 31) begin
        exp_r("sat_c_hold", C_SCNT, 15);
        exp_r("sat_a_16", A_SCNT, 16);
      end
      step();
    end
    idle();
    exp_c("sat_c_end", C_SCNT, 15);
    exp_c("sat_a_end", A_SCNT, 20);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
